// File: rtl/tnkk_accum_tree_pkg.sv
// Shared defaults and constant helpers for the select array and the accumulate tree.
package tnkk_accum_tree_pkg;

  localparam int unsigned DEF_TN            = 4;
  localparam int unsigned DEF_KERNEL_SIZE   = 5;
  localparam int unsigned DEF_FEATURE_WIDTH = 8;
  localparam int unsigned DEF_BIAS_WIDTH    = 16;
  localparam int unsigned DEF_MAX_TILES     = 64;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tnkk_adder_stage.sv
// One registered level of the reduction tree: pairwise adds plus valid/sideband register.
module tnkk_adder_stage #(
  parameter int unsigned W       = 22,
  parameter int unsigned CNT_OUT = 1,
  parameter int unsigned SB_W    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   vld_i,
  input  logic [SB_W-1:0]        sb_i,
  input  logic [2*CNT_OUT*W-1:0] data_i,
  output logic                   vld_o,
  output logic [SB_W-1:0]        sb_o,
  output logic [CNT_OUT*W-1:0]   data_o
);

  logic                 vld_q;
  logic [SB_W-1:0]      sb_q;
  logic [CNT_OUT*W-1:0] data_q;
  logic [CNT_OUT*W-1:0] sum_d;

  // Adjacent element pairs summed; widths already cover the full tree growth.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < CNT_OUT; j++) begin
      sum_d[j*W +: W] = data_i[2*j*W +: W] + data_i[(2*j+1)*W +: W];
    end
  end

  // Data and sideband only load on valid; clear kills the valid bit, dropping in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sb_q   <= '0;
      data_q <= '0;
    end else if (clear) begin
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        sb_q   <= sb_i;
        data_q <= sum_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign sb_o   = sb_q;
  assign data_o = data_q;

endmodule

// File: rtl/tnkk_accum_tree.sv
// Adder-tree reduction of a product vector followed by per-group tile accumulation with bias.
module tnkk_accum_tree
  import tnkk_accum_tree_pkg::*;
#(
  parameter int unsigned  Tn            = DEF_TN,
  parameter int unsigned  KERNEL_SIZE   = DEF_KERNEL_SIZE,
  parameter int unsigned  FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int unsigned  BIAS_WIDTH    = DEF_BIAS_WIDTH,
  parameter int unsigned  MAX_TILES     = DEF_MAX_TILES,
  localparam int unsigned N             = Tn * KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned TILE_W        = clog2(MAX_TILES + 1),
  localparam int unsigned ACC_WIDTH     = FEATURE_WIDTH + clog2(N) + clog2(MAX_TILES) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*FEATURE_WIDTH-1:0] products_in,
  input  logic                       products_vld,
  input  logic [TILE_W-1:0]          num_tiles,
  input  logic [BIAS_WIDTH-1:0]      bias_in,
  input  logic                       clear,
  output logic [ACC_WIDTH-1:0]       result,
  output logic                       result_vld,
  output logic                       busy
);

  localparam int unsigned STAGES = clog2(N);
  localparam int unsigned PAD    = 32'd1 << STAGES;
  localparam int unsigned TOT    = 2 * PAD - 1;
  localparam int unsigned SB_W   = TILE_W + BIAS_WIDTH;

  // All tree levels packed back to back: level s starts at element 2*PAD - (2*PAD >> s).
  logic [TOT*ACC_WIDTH-1:0] tree_bus;
  logic [PAD*ACC_WIDTH-1:0] leaf_c;
  logic [STAGES:0]          vld_bus;
  logic [SB_W-1:0]          sb_bus [STAGES+1];

  // Leaves: sign-extend every product, zero-pad up to the power-of-two width.
  always_comb begin
    leaf_c = '0;
    for (int i = 0; i < N; i++) begin
      leaf_c[i*ACC_WIDTH +: ACC_WIDTH] =
        ACC_WIDTH'($signed(products_in[i*FEATURE_WIDTH +: FEATURE_WIDTH]));
    end
  end

  assign tree_bus[PAD*ACC_WIDTH-1:0] = leaf_c;
  assign vld_bus[0]                  = products_vld;
  assign sb_bus[0]                   = {num_tiles, bias_in};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned CNT_OUT = PAD >> (s + 1);
    localparam int unsigned IN_OFF  = 2 * PAD - ((2 * PAD) >> s);
    localparam int unsigned OUT_OFF = 2 * PAD - (PAD >> s);

    tnkk_adder_stage #(
      .W       (ACC_WIDTH),
      .CNT_OUT (CNT_OUT),
      .SB_W    (SB_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .vld_i  (vld_bus[s]),
      .sb_i   (sb_bus[s]),
      .data_i (tree_bus[IN_OFF*ACC_WIDTH +: 2*CNT_OUT*ACC_WIDTH]),
      .vld_o  (vld_bus[s+1]),
      .sb_o   (sb_bus[s+1]),
      .data_o (tree_bus[OUT_OFF*ACC_WIDTH +: CNT_OUT*ACC_WIDTH])
    );
  end

  logic [ACC_WIDTH-1:0]  tree_sum_c;
  logic                  tree_vld_c;
  logic [TILE_W-1:0]     tree_tiles_c;
  logic [BIAS_WIDTH-1:0] tree_bias_c;

  assign tree_sum_c                  = tree_bus[(TOT-1)*ACC_WIDTH +: ACC_WIDTH];
  assign tree_vld_c                  = vld_bus[STAGES];
  assign {tree_tiles_c, tree_bias_c} = sb_bus[STAGES];

  logic [ACC_WIDTH-1:0] acc_q, acc_d, result_q, result_d, base_c, acc_nxt_c;
  logic [TILE_W-1:0]    tile_cnt_q, tile_cnt_d, n_q, n_d, n_use_c, tiles_eff_c;
  logic                 result_vld_q, result_vld_d;

  // Accumulate next-state: first tile seeds from bias, last tile publishes the running sum.
  always_comb begin
    acc_d        = acc_q;
    tile_cnt_d   = tile_cnt_q;
    n_d          = n_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    tiles_eff_c  = (tree_tiles_c == '0) ? TILE_W'(1) : tree_tiles_c;
    base_c       = acc_q;
    n_use_c      = n_q;
    if (tile_cnt_q == '0) begin
      base_c  = ACC_WIDTH'($signed(tree_bias_c));
      n_use_c = tiles_eff_c;
    end
    acc_nxt_c = base_c + tree_sum_c;
    if (clear) begin
      acc_d      = '0;
      tile_cnt_d = '0;
    end else if (tree_vld_c) begin
      acc_d = acc_nxt_c;
      n_d   = n_use_c;
      if (tile_cnt_q == n_use_c - TILE_W'(1)) begin
        result_d     = acc_nxt_c;
        result_vld_d = 1'b1;
        tile_cnt_d   = '0;
      end else begin
        tile_cnt_d = tile_cnt_q + TILE_W'(1);
      end
    end
  end

  // Accumulator, tile counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      tile_cnt_q   <= '0;
      n_q          <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      tile_cnt_q   <= tile_cnt_d;
      n_q          <= n_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign busy       = (|vld_bus[STAGES:1]) | (tile_cnt_q != '0);

endmodule

// File: tb/tb_tnkk_accum_tree.sv
// Self-checking bench: group-level reference model with a per-cycle output compare.
module tb_tnkk_accum_tree;

  localparam int unsigned N   = 100;
  localparam int unsigned FW  = 8;
  localparam int unsigned BW  = 16;
  localparam int unsigned TW  = 7;
  localparam int unsigned AW  = 22;
  localparam int          LAT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*FW-1:0] products_in;
  logic            products_vld;
  logic [TW-1:0]   num_tiles;
  logic [BW-1:0]   bias_in;
  logic            clear;
  logic [AW-1:0]   result;
  logic            result_vld;
  logic            busy;

  tnkk_accum_tree dut (
    .clk          (clk),
    .rst          (rst),
    .products_in  (products_in),
    .products_vld (products_vld),
    .num_tiles    (num_tiles),
    .bias_in      (bias_in),
    .clear        (clear),
    .result       (result),
    .result_vld   (result_vld),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t             q[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  int               exp_res  = 0;
  bit               chk_on   = 1'b0;
  int               m_cnt    = 0;
  int               m_n      = 1;
  int               m_acc    = 0;
  int               last_t   = 0;
  logic signed [7:0] vec [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Group model: each group yields bias + sum of all its vectors, LAT cycles after the last one.
  task automatic model_vec(input int tiles, input int bias, input bit clr);
    int s = 0;
    if (clr) begin
      m_cnt = 0;
      m_acc = 0;
      return;
    end
    for (int i = 0; i < N; i++) s += int'(vec[i]);
    if (m_cnt == 0) begin
      m_n   = (tiles == 0) ? 1 : tiles;
      m_acc = bias + s;
    end else begin
      m_acc += s;
    end
    m_cnt++;
    if (m_cnt == m_n) begin
      q.push_back('{due: cyc + LAT, val: m_acc});
      m_cnt = 0;
    end
  endtask

  task automatic send(input int tiles, input int bias, input bit clr);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) products_in[i*FW +: FW] = vec[i];
    products_vld = 1'b1;
    num_tiles    = TW'(tiles);
    bias_in      = BW'(bias);
    clear        = clr;
    last_t       = cyc;
    model_vec(tiles, bias, clr);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      products_vld = 1'b0;
      clear        = 1'b0;
    end
  endtask

  task automatic set_vec(input int v);
    for (int i = 0; i < N; i++) vec[i] = 8'(v);
  endtask

  // Waits (bounded) for the next result pulse and pins value and latency to hand-computed numbers.
  task automatic wait_lit(input string name, input int lit, input int t_ref);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = result_vld;
    end
    check({name, " seen"}, int'(seen), 1);
    check({name, " value"}, int'($signed(result)), lit);
    check({name, " latency"}, cyc - t_ref, LAT);
  endtask

  // Every cycle: result_vld exactly when the model says a group completes, result always tracks.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("result_vld", int'(result_vld), int'(ev));
      if (ev) begin
        exp_res = q[0].val;
        void'(q.pop_front());
      end
      check("result", int'($signed(result)), exp_res);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst          = 1'b1;
    products_vld = 1'b0;
    products_in  = '0;
    num_tiles    = '0;
    bias_in      = '0;
    clear        = 1'b0;
    set_vec(0);
    #2;
    check("reset result", int'(result), 0);
    check("reset result_vld", int'(result_vld), 0);
    check("reset busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Single tile of ones.
    set_vec(1);
    send(1, 0, 1'b0);
    t = last_t;
    idle(1);
    wait_lit("t1", 100, t);
    @(negedge clk);
    check("t1 single pulse", int'(result_vld), 0);

    // Three tiles of -1 with gaps 0 and 2, bias -5.
    idle(3);
    set_vec(-1);
    send(3, -5, 1'b0);
    send(3, -5, 1'b0);
    idle(2);
    send(3, -5, 1'b0);
    t = last_t;
    idle(1);
    wait_lit("t2", -305, t);

    // Back-to-back groups.
    idle(3);
    set_vec(2);
    send(2, 1, 1'b0);
    send(2, 1, 1'b0);
    t = last_t;
    set_vec(-3);
    send(1, 0, 1'b0);
    idle(1);
    wait_lit("t3a", 401, t);
    @(negedge clk);
    check("t3b vld", int'(result_vld), 1);
    check("t3b value", int'($signed(result)), -300);

    // Mixed-sign vector, num_tiles=0 behaves as 1.
    idle(3);
    for (int i = 0; i < N; i++) vec[i] = (i % 2 != 0) ? -8'sd128 : 8'sd127;
    send(0, 0, 1'b0);
    t = last_t;
    idle(1);
    wait_lit("t4", -50, t);

    // Clear with the second vector of a 4-tile group.
    idle(10);
    set_vec(1);
    send(4, 0, 1'b0);
    idle(10);
    check("t5 busy open", int'(busy), 1);
    send(4, 0, 1'b1);
    idle(12);
    check("t5 busy cleared", int'(busy), 0);
    send(1, 7, 1'b0);
    t = last_t;
    idle(1);
    wait_lit("t5", 107, t);
    idle(10);
    check("t5 busy done", int'(busy), 0);

    // Asynchronous reset mid-group.
    for (int i = 0; i < N; i++) vec[i] = 8'($urandom);
    send(3, 0, 1'b0);
    idle(2);
    #3 rst = 1'b1;
    q.delete();
    m_cnt   = 0;
    exp_res = 0;
    #1;
    check("t6 result", int'(result), 0);
    check("t6 result_vld", int'(result_vld), 0);
    check("t6 busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    set_vec(1);
    send(1, 3, 1'b0);
    t = last_t;
    idle(1);
    wait_lit("t6", 103, t);

    // Randomized groups, random gaps, back-to-back boundaries.
    idle(4);
    for (int g = 0; g < 40; g++) begin
      int tiles, bias, n;
      tiles = (g == 20) ? 64 : int'($urandom_range(0, 5));
      bias  = int'($signed(16'($urandom)));
      n     = (tiles == 0) ? 1 : tiles;
      for (int k = 0; k < n; k++) begin
        for (int i = 0; i < N; i++) vec[i] = 8'($urandom);
        send(tiles, bias, 1'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    idle(15);
    check("drained", q.size(), 0);
    check("final busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
